// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit, one result bit per cycle.
// Produces {hi,lo} for the HI/LO write path; E stalls on busy_o.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_q, mul_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    acc_div, acc_mul, acc_nx;
    logic [AW-1:0]    prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    assign a_neg = op_i[0] & a_i[WIDTH-1];
    assign b_neg = op_i[0] & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // Shifted partial remainder carries one extra bit above the W-bit remainder
    assign div_sh  = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, b_q};
    assign div_sub = div_sh[WIDTH-1:0] - b_q;
    assign acc_div = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                            : {acc_q[AW-2:0], 1'b0};

    assign mul_sum = {1'b0, acc_q[AW-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

    assign acc_nx = mul_q ? acc_mul : acc_div;
    assign prod_s = qneg_q ? -acc_nx : acc_nx;
    assign quo_s  = qneg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
    assign rem_s  = rneg_q ? -acc_nx[AW-1:WIDTH] : acc_nx[AW-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (cancel_i) begin
            state_d = S_IDLE;
        end else if (state_q == S_BUSY) begin
            acc_d = acc_nx;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_DONE;
                if (mul_q) begin
                    {hi_d, lo_d} = prod_s;
                end else begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
            end
        end else if (start_i) begin
            mul_d  = op_i[1];
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            if (!op_i[1] && b_i == '0) begin
                state_d = S_DONE;
                cnt_d   = '0;
                hi_d    = a_i;
                lo_d    = '1;
            end else begin
                state_d = S_BUSY;
                cnt_d   = CNT_W'(WIDTH);
                b_d     = op_i[1] ? a_mag : b_mag;
                acc_d   = {{WIDTH{1'b0}}, (op_i[1] ? b_mag : a_mag)};
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = (state_q == S_BUSY);
    assign done_o = (state_q == S_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule
